// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings
// and frame geometry.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
      S_STOP    = 3'd3,
      S_CLEANUP = 3'd4
   } uart_state_e;

   localparam int DATA_BITS = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous pin.
// Resets to 1 so an idle-high line never looks active.
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= i_d;
         sync_q <= meta_q;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start qualified at mid-bit, data sampled
// at bit centres, one-cycle byte-valid and framing-error pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Rx_Frame_Err,
   output logic       o_Rx_Active
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

   logic rx_s;

   uart_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [7:0]    byte_q, byte_d;
   logic          dv_q, dv_d;
   logic          ferr_q, ferr_d;
   logic          active_q, active_d;

   sync_2ff u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_Rx_Serial),
      .o_q     (rx_s)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shreg_d  = shreg_q;
      byte_d   = byte_q;
      dv_d     = 1'b0;
      ferr_d   = 1'b0;
      active_d = active_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (!rx_s) begin
               state_d  = S_START;
               active_d = 1'b1;
            end
         end
         S_START: begin
            if (cnt_q == HALF) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d = S_DATA;
               end else begin
                  state_d  = S_IDLE;
                  active_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == LAST) begin
               cnt_d          = '0;
               shreg_d[idx_q] = rx_s;
               if (idx_q == LAST_IDX) begin
                  state_d = S_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == LAST) begin
               cnt_d    = '0;
               active_d = 1'b0;
               state_d  = S_CLEANUP;
               if (rx_s) begin
                  byte_d = shreg_q;
                  dv_d   = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         // Hold off until the line is released so a break is not
         // mistaken for a fresh start bit.
         S_CLEANUP: begin
            if (rx_s) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            idx_d    = '0;
            active_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shreg_q  <= '0;
         byte_q   <= '0;
         dv_q     <= 1'b0;
         ferr_q   <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shreg_q  <= shreg_d;
         byte_q   <= byte_d;
         dv_q     <= dv_d;
         ferr_q   <= ferr_d;
         active_q <= active_d;
      end
   end

   assign o_Rx_DV        = dv_q;
   assign o_Rx_Byte      = byte_q;
   assign o_Rx_Frame_Err = ferr_q;
   assign o_Rx_Active    = active_q;

endmodule
